cordic_pipe: RTL and testbench



---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_stage.sv | 57 +++++
 rtl/cordic_pipe.sv | 109 ++++++++++
 tb/tb_cordic_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC: mode encoding, arctangent table,
// and the shift-add terms used for 1/K gain compensation.
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } mode_e;

    // round(atan(2^-i) * 2^32 / (2*pi)); narrower widths are rounded from this.
    localparam logic [31:0] ATAN_TAB32 [0:31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 = 0.607239
    localparam int unsigned GC_TERMS = 6;
    localparam int unsigned GC_SHIFT [0:GC_TERMS-1] = '{1, 3, 6, 9, 12, 14};
    localparam bit          GC_NEG   [0:GC_TERMS-1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam int unsigned GC_FRAC  = 14;

    function automatic logic [31:0] atan_angle(input int unsigned i, input int unsigned width);
        logic [32:0] t;
        if (i > 31) return '0;
        if (width >= 32) return ATAN_TAB32[i];
        t = {1'b0, ATAN_TAB32[i]} + (33'd1 << (31 - width));
        return 32'(t >> (32 - width));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation: shift by SHIFT, table angle ANGLE,
// direction chosen from z sign (rotation) or y sign (vectoring).
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int          SHIFT = 0,
    parameter logic [31:0] ANGLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             valid_out,
    output logic             mode_out,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);

    logic signed [WIDTH-1:0] dx;
    logic signed [WIDTH-1:0] dy;
    logic [WIDTH-1:0]        angle;
    logic                    sigma;

    assign dx    = $signed(y_in) >>> SHIFT;
    assign dy    = $signed(x_in) >>> SHIFT;
    assign angle = ANGLE[WIDTH-1:0];
    assign sigma = (mode_in == MODE_VEC) ? ~y_in[WIDTH-1] : z_in[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            mode_out  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else if (en) begin
            valid_out <= valid_in;
            mode_out  <= mode_in;
            if (sigma) begin
                x_out <= x_in + dx;
                y_out <= y_in - dy;
                z_out <= z_in + angle;
            end else begin
                x_out <= x_in - dx;
                y_out <= y_in + dy;
                z_out <= z_in - angle;
            end
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC with valid/ready streaming and a global stall.
// Optional 1/K output stage is compiled in with CORDIC_GAIN_COMP_EN.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_mode
);

    logic             adv;
    logic             v_s [0:ITER];
    logic             m_s [0:ITER];
    logic [WIDTH-1:0] x_s [0:ITER];
    logic [WIDTH-1:0] y_s [0:ITER];
    logic [WIDTH-1:0] z_s [0:ITER];

    // Whole pipe moves or holds together, bubbles included.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;

    assign v_s[0] = in_valid;
    assign m_s[0] = in_mode;
    assign x_s[0] = x_in;
    assign y_s[0] = y_in;
    assign z_s[0] = z_in;

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        cordic_stage #(
            .WIDTH (WIDTH),
            .SHIFT (i),
            .ANGLE (atan_angle(i, WIDTH))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .valid_in  (v_s[i]),
            .mode_in   (m_s[i]),
            .x_in      (x_s[i]),
            .y_in      (y_s[i]),
            .z_in      (z_s[i]),
            .valid_out (v_s[i+1]),
            .mode_out  (m_s[i+1]),
            .x_out     (x_s[i+1]),
            .y_out     (y_s[i+1]),
            .z_out     (z_s[i+1])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXT = WIDTH + GC_FRAC;

    logic signed [EXT-1:0] xe, ye, xc, yc;

    // Extra fraction bits keep the shifted partial terms from truncating early.
    always_comb begin
        xe = {x_s[ITER], {GC_FRAC{1'b0}}};
        ye = {y_s[ITER], {GC_FRAC{1'b0}}};
        xc = '0;
        yc = '0;
        for (int unsigned k = 0; k < GC_TERMS; k++) begin
            if (GC_NEG[k]) begin
                xc = xc - (xe >>> GC_SHIFT[k]);
                yc = yc - (ye >>> GC_SHIFT[k]);
            end else begin
                xc = xc + (xe >>> GC_SHIFT[k]);
                yc = yc + (ye >>> GC_SHIFT[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else if (adv) begin
            out_valid <= v_s[ITER];
            out_mode  <= m_s[ITER];
            x_out     <= xc[EXT-1:GC_FRAC];
            y_out     <= yc[EXT-1:GC_FRAC];
            z_out     <= z_s[ITER];
        end
    end
`else
    assign out_valid = v_s[ITER];
    assign out_mode  = m_s[ITER];
    assign x_out     = x_s[ITER];
    assign y_out     = y_s[ITER];
    assign z_out     = z_s[ITER];
`endif

endmodule

// File: tb/tb_cordic_pipe.sv
// Self-checking bench for cordic_pipe (WIDTH=16, ITER=14): directed points,
// random streaming with backpressure, mixed modes and mid-stream reset.
module tb_cordic_pipe;

    localparam int W = 16;
    localparam int N = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = N + 1;
    localparam int TOL = 2;
`else
    localparam int LAT = N;
    localparam int TOL = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [W-1:0] x_in, y_in, z_in, x_out, y_out, z_out;

    typedef struct { logic m; int x; int y; int z; int c; } exp_t;
    exp_t q[$];

    int  n_pass = 0, n_chk = 0, n_out = 0, cyc = 0;
    int  ang [0:N-1];
    bit  chk_lat = 0, stall_prev = 0, last_acc = 0;
    logic [W-1:0] hx, hy, hz;
    logic         hm;
    int  lx, ly, lz;
    logic lm;

    cordic_pipe #(.WIDTH(W), .ITER(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    function automatic int wrap16(input int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Reference CORDIC on plain integers, angles from real-valued atan.
    function automatic exp_t model(input logic m, input int x0, input int y0, input int z0);
        exp_t e;
        int x, y, z, nx, ny;
        bit s;
        x = wrap16(x0); y = wrap16(y0); z = wrap16(z0);
        for (int i = 0; i < N; i++) begin
            s = (m == 1'b1) ? (y >= 0) : (z < 0);
            if (s) begin
                nx = x + (y >>> i); ny = y - (x >>> i); z = z + ang[i];
            end else begin
                nx = x - (y >>> i); ny = y + (x >>> i); z = z - ang[i];
            end
            x = wrap16(nx); y = wrap16(ny); z = wrap16(z);
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = rnd(real'(x) * 0.6072529350);
        y = rnd(real'(y) * 0.6072529350);
`endif
        e.m = m; e.x = x; e.y = y; e.z = z; e.c = 0;
        return e;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) begin n_pass++; end
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        bit ok;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        n_chk++;
        assert (ok === 1'b1) begin n_pass++; end
        else $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
    endtask

    // One clock: drive at negedge, then check outputs/handshakes 1 time unit later.
    task automatic step(input logic v, input logic m, input int x, input int y, input int z,
                        input logic ordy);
        exp_t e;
        @(negedge clk);
        cyc++;
        in_valid = v; in_mode = m;
        x_in = W'(x); y_in = W'(y); z_in = W'(z);
        out_ready = ordy;
        #1;
        check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready) && !rst));
        if (stall_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_x", int'(x_out), int'(hx));
            check("hold_y", int'(y_out), int'(hy));
            check("hold_z", int'(z_out), int'(hz));
            check("hold_mode", int'(out_mode), int'(hm));
        end
        if (out_valid && out_ready) begin
            check("out_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_mode", int'(out_mode), int'(e.m));
                check_tol("x_out", $signed(x_out), e.x, TOL);
                check_tol("y_out", $signed(y_out), e.y, TOL);
                check("z_out", $signed(z_out), e.z);
                if (chk_lat) check("latency", cyc - e.c, LAT);
            end
            lx = $signed(x_out); ly = $signed(y_out); lz = $signed(z_out); lm = out_mode;
            n_out++;
        end
        stall_prev = out_valid && !out_ready;
        hx = x_out; hy = y_out; hz = z_out; hm = out_mode;
        last_acc = v && in_ready;
        if (last_acc) begin
            e = model(m, x, y, z);
            e.c = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain(input int target);
        int k;
        k = 0;
        while (n_out < target && k < 200) begin
            step(1'b0, 1'b0, 0, 0, 0, 1'b1);
            k++;
        end
        check("drain_done", int'(n_out >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, i, g, pre_ov;
        logic sm [0:19];
        int   sx [0:19], sy [0:19], sz [0:19];

        for (int k = 0; k < N; k++)
            ang[k] = rnd($atan(2.0 ** (-k)) * 65536.0 / (2.0 * 3.14159265358979));

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        check("rst_z", int'(z_out), 0);
        check("rst_mode", int'(out_mode), 0);
        check("rst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk_lat = 1;
`ifdef CORDIC_GAIN_COMP_EN
        base = n_out;
        step(1'b1, 1'b0, 10000, 0, 0, 1'b1);
        drain(base + 1);
        check_tol("gc_x", lx, 10000, 8);
        check_tol("gc_y", ly, 0, 4);
        check_tol("gc_z", lz, 0, 2);
        check("gc_mode", int'(lm), 0);
`else
        base = n_out;
        step(1'b1, 1'b0, 9949, 0, 16'h2000, 1'b1);
        drain(base + 1);
        check_tol("rot45_x", lx, 11585, 4);
        check_tol("rot45_y", ly, 11585, 4);
        check_tol("rot45_z", lz, 0, 2);
        check("rot45_mode", int'(lm), 0);

        base = n_out;
        step(1'b1, 1'b1, 10000, 10000, 0, 1'b1);
        drain(base + 1);
        check_tol("vec_x", lx, 23290, 6);
        check_tol("vec_y", ly, 0, 2);
        check_tol("vec_z", lz, 16'h2000, 2);
        check("vec_mode", int'(lm), 1);
`endif

        // Mixed modes back to back.
        base = n_out;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) step(1'b1, 1'b0, 9949, 0, 16'h2000, 1'b1);
            else            step(1'b1, 1'b1, 10000, 10000, 0, 1'b1);
        end
        drain(base + 8);
        check("mixed_last_mode", int'(lm), 1);

        // Random streaming with out_ready toggling every 3 cycles.
        chk_lat = 0;
        for (int k = 0; k < 20; k++) begin
            sm[k] = 1'($urandom_range(1));
            if (sm[k]) begin
                sx[k] = 1 + int'($urandom_range(7999));
                sy[k] = int'($urandom_range(16000)) - 8000;
                sz[k] = int'($urandom_range(65535));
            end else begin
                sx[k] = int'($urandom_range(16000)) - 8000;
                sy[k] = int'($urandom_range(16000)) - 8000;
                sz[k] = int'($urandom_range(36000)) - 18000;
            end
        end
        base = n_out; i = 0; g = 0;
        while (i < 20 && g < 400) begin
            step(1'b1, sm[i], sx[i], sy[i], sz[i], ((cyc / 3) % 2) == 0);
            if (last_acc) i++;
            g++;
        end
        check("stream_accepted", i, 20);
        drain(base + 20);
        check("stream_count", n_out - base, 20);
        check("stream_queue_empty", q.size(), 0);

        // Reset with samples in flight and a result waiting at the output.
        for (int k = 0; k < LAT + 5; k++)
            step(1'b1, 1'b0, int'($urandom_range(16000)) - 8000, 0, 16'h1000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        pre_ov = int'(out_valid);
        check("pre_rst_valid", pre_ov, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_x", int'(x_out), 0);
        check("midrst_y", int'(y_out), 0);
        check("midrst_z", int'(z_out), 0);
        check("midrst_mode", int'(out_mode), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        q.delete();
        stall_prev = 0;
        step(1'b0, 1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        base = n_out;
        repeat (30) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("no_stale_after_rst", n_out - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
